// File: rtl/bp_be_pkg.sv
// Shared definitions for the backend reference-prediction-table prefetcher.
//   - DECLARE_BP_BE_RPT_ENTRY_S: declares the per-way table entry struct for
//     a given tag / address / stride / confidence width.
//   - bp_params_e / bp_vaddr_width: processor configurations and their
//     virtual address width.
//   - bp_be_rpt_init_state_e: table initialisation FSM states.
//   - bp_be_rpt_issue_state_e: prefetch issue FSM states.
// Optional feature macro used by the users of this package:
// BP_BE_RPT_NEG_STRIDE_EN (signed strides).

`define DECLARE_BP_BE_RPT_ENTRY_S(tag_width_mp, vaddr_width_mp, stride_width_mp, conf_width_mp) \
  typedef struct packed { \
    logic                       valid; \
    logic [tag_width_mp-1:0]    tag; \
    logic [vaddr_width_mp-1:0]  last_addr; \
    logic [stride_width_mp-1:0] stride; \
    logic [conf_width_mp-1:0]   conf; \
  } bp_be_rpt_entry_s

package bp_be_pkg;

  typedef enum logic {
    e_bp_default_cfg = 1'b0,
    e_bp_sv32_cfg    = 1'b1
  } bp_params_e;

  function automatic int bp_vaddr_width(bp_params_e cfg);
    return (cfg == e_bp_sv32_cfg) ? 32 : 39;
  endfunction

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_clear = 2'd1,
    e_run   = 2'd2
  } bp_be_rpt_init_state_e;

  typedef enum logic {
    e_idle  = 1'b0,
    e_issue = 1'b1
  } bp_be_rpt_issue_state_e;

endpackage

// File: rtl/bp_be_rpt_nway_issue.sv
// Prefetch issue FSM and address generation.
//   pred_v_i/pred_base_i/pred_stride_i/pred_pc_i : confirmed prediction
//   flush_i    : abandon the current burst
//   pf_v_o/pf_ready_i : valid/ready prefetch request; pf_addr_o/pf_pc_o are
//                registered and only change on a handshake or a new burst,
//                so they hold stable while pf_v_o & ~pf_ready_i
//   state_o    : issue FSM state (debug)
// BP_BE_RPT_NEG_STRIDE_EN: stride sign-extended, otherwise zero-extended.
module bp_be_rpt_nway_issue
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int stride_width_p = 12,
  parameter int degree_p = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic                      pred_v_i,
  input  logic [vaddr_width_p-1:0]  pred_base_i,
  input  logic [stride_width_p-1:0] pred_stride_i,
  input  logic [vaddr_width_p-1:0]  pred_pc_i,
  output logic                      pf_v_o,
  input  logic                      pf_ready_i,
  output logic [vaddr_width_p-1:0]  pf_addr_o,
  output logic [vaddr_width_p-1:0]  pf_pc_o,
  output bp_be_rpt_issue_state_e    state_o
);

  localparam int k_width_lp = $clog2(degree_p + 1);

  bp_be_rpt_issue_state_e   state_r;
  logic [k_width_lp-1:0]    k_r;
  logic [vaddr_width_p-1:0] stride_r;
  logic [vaddr_width_p-1:0] addr_r;
  logic [vaddr_width_p-1:0] pc_r;
  logic [vaddr_width_p-1:0] stride_ext;

`ifdef BP_BE_RPT_NEG_STRIDE_EN
  assign stride_ext = {{(vaddr_width_p-stride_width_p){pred_stride_i[stride_width_p-1]}}, pred_stride_i};
`else
  assign stride_ext = {{(vaddr_width_p-stride_width_p){1'b0}}, pred_stride_i};
`endif

  // addr_r always equals base + k*stride: seeded with base+stride, then
  // advanced by one stride per accepted request.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r  <= e_idle;
      k_r      <= k_width_lp'(1);
      stride_r <= '0;
      addr_r   <= '0;
      pc_r     <= '0;
    end else if (flush_i) begin
      state_r <= e_idle;
      k_r     <= k_width_lp'(1);
    end else begin
      case (state_r)
        e_idle: begin
          if (pred_v_i) begin
            state_r  <= e_issue;
            k_r      <= k_width_lp'(1);
            stride_r <= stride_ext;
            addr_r   <= pred_base_i + stride_ext;
            pc_r     <= pred_pc_i;
          end
        end
        e_issue: begin
          // New predictions are dropped while a burst is in flight.
          if (pf_ready_i) begin
            if (k_r == k_width_lp'(degree_p)) begin
              state_r <= e_idle;
              k_r     <= k_width_lp'(1);
            end else begin
              k_r    <= k_r + k_width_lp'(1);
              addr_r <= addr_r + stride_r;
            end
          end
        end
        default: state_r <= e_idle;
      endcase
    end
  end

  assign pf_v_o    = (state_r == e_issue);
  assign pf_addr_o = addr_r;
  assign pf_pc_o   = pc_r;
  assign state_o   = state_r;

endmodule

// File: rtl/bsg_mem_1r1w_sync.sv
// One-read one-write synchronous RAM.
//   w_v_i/w_addr_i/w_data_i : write port, written on the rising edge
//   r_v_i/r_addr_i          : read request, data appears on r_data_o the
//                             cycle after; r_data_o holds until next read
// A read and write to the same row in one cycle returns the old contents.
module bsg_mem_1r1w_sync #(
  parameter int width_p = 8,
  parameter int els_p = 2,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (w_v_i) mem[w_addr_i] <= w_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (r_v_i) r_data_o <= mem[r_addr_i];
  end

endmodule

// File: rtl/bp_be_rpt_nway.sv
// N-way set-associative reference prediction table (stride prefetcher).
//   clk_i, reset_i        : clock, synchronous active-high reset
//   init_done_o           : table cleared and accepting loads
//   v_i, pc_i, eff_addr_i : retired load observation
//   flush_i               : abort an in-progress prefetch burst
//   pf_v_o, pf_ready_i    : valid/ready prefetch request (accepted when both
//                           high on a rising edge), pf_addr_o/pf_pc_o payload
//   init_state_o, issue_state_o : FSM states (debug)
// BP_BE_RPT_NEG_STRIDE_EN: strides are signed; otherwise a stride with its
// MSB set never gains confidence.
module bp_be_rpt_nway
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int sets_p = 32,
  parameter int ways_p = 4,
  parameter int stride_width_p = 12,
  parameter int conf_width_p = 2,
  parameter int degree_p = 2,
  localparam int vaddr_width_p = bp_vaddr_width(bp_params_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic                     init_done_o,
  input  logic                     v_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic [vaddr_width_p-1:0] eff_addr_i,
  input  logic                     flush_i,
  output logic                     pf_v_o,
  input  logic                     pf_ready_i,
  output logic [vaddr_width_p-1:0] pf_addr_o,
  output logic [vaddr_width_p-1:0] pf_pc_o,
  output bp_be_rpt_init_state_e    init_state_o,
  output bp_be_rpt_issue_state_e   issue_state_o
);

  localparam int idx_width_lp = $clog2(sets_p);
  localparam int tag_width_lp = vaddr_width_p - idx_width_lp;
  localparam int ptr_width_lp = (ways_p > 1) ? $clog2(ways_p) : 1;
  localparam logic [conf_width_p-1:0] conf_max_lp = '1;

  `DECLARE_BP_BE_RPT_ENTRY_S(tag_width_lp, vaddr_width_p, stride_width_p, conf_width_p);

  typedef struct packed {
    bp_be_rpt_entry_s [ways_p-1:0] way;
    logic [ptr_width_lp-1:0]       victim;
  } row_s;

  localparam int row_width_lp = $bits(row_s);

  // Init FSM: walk every set writing zeros, then accept loads.
  bp_be_rpt_init_state_e   init_state_r;
  logic [idx_width_lp-1:0] clear_idx_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      init_state_r <= e_reset;
      clear_idx_r  <= '0;
    end else begin
      case (init_state_r)
        e_reset: begin
          init_state_r <= e_clear;
          clear_idx_r  <= '0;
        end
        e_clear: begin
          clear_idx_r <= clear_idx_r + idx_width_lp'(1);
          if (clear_idx_r == idx_width_lp'(sets_p - 1)) init_state_r <= e_run;
        end
        e_run:   init_state_r <= e_run;
        default: init_state_r <= e_reset;
      endcase
    end
  end

  assign init_done_o  = (init_state_r == e_run);
  assign init_state_o = init_state_r;

  // Stage 0: read the set, latch the load.
  logic                     rd_v;
  logic [idx_width_lp-1:0]  rd_idx;
  logic                     s1_v_r;
  logic [vaddr_width_p-1:0] s1_pc_r, s1_addr_r;

  assign rd_v   = v_i & init_done_o;
  assign rd_idx = pc_i[idx_width_lp-1:0];

  always_ff @(posedge clk_i) begin
    if (reset_i) s1_v_r <= 1'b0;
    else         s1_v_r <= rd_v;
  end

  always_ff @(posedge clk_i) begin
    if (rd_v) begin
      s1_pc_r   <= pc_i;
      s1_addr_r <= eff_addr_i;
    end
  end

  // Stage 1: compare, update, write back.
  logic [idx_width_lp-1:0] s1_idx;
  logic [tag_width_lp-1:0] s1_tag;
  logic [row_width_lp-1:0] rd_row_bits;
  row_s                    row_cur, row_upd, fwd_row_r;
  logic                    fwd_v_r;
  logic                    hit;
  logic [ptr_width_lp-1:0] hit_way, next_victim;
  bp_be_rpt_entry_s        hit_entry;
  logic [stride_width_p-1:0] new_stride, stride_n;
  logic [conf_width_p-1:0] conf_n;
  logic                    stride_legal, pred_v;

  assign s1_idx = s1_pc_r[idx_width_lp-1:0];
  assign s1_tag = s1_pc_r[vaddr_width_p-1:idx_width_lp];

  // The RAM returns pre-write data when the previous load wrote the same
  // set in the cycle this one was read; substitute that write instead.
  assign row_cur   = fwd_v_r ? fwd_row_r : row_s'(rd_row_bits);
  assign hit_entry = row_cur.way[hit_way];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < ways_p; w++) begin
      if (!hit && row_cur.way[w].valid && (row_cur.way[w].tag == s1_tag)) begin
        hit     = 1'b1;
        hit_way = ptr_width_lp'(w);
      end
    end
  end

  always_comb begin
    row_upd     = row_cur;
    new_stride  = s1_addr_r[stride_width_p-1:0] - hit_entry.last_addr[stride_width_p-1:0];
`ifdef BP_BE_RPT_NEG_STRIDE_EN
    stride_legal = 1'b1;
`else
    stride_legal = ~new_stride[stride_width_p-1];
`endif
    conf_n      = '0;
    stride_n    = '0;
    next_victim = (ways_p == 1) ? '0 : row_cur.victim + ptr_width_lp'(1);
    if (hit) begin
      if (stride_legal && (new_stride == hit_entry.stride))
        conf_n = (hit_entry.conf == conf_max_lp) ? conf_max_lp : hit_entry.conf + conf_width_p'(1);
      stride_n = new_stride;
      row_upd.way[hit_way] = '{valid: 1'b1, tag: s1_tag, last_addr: s1_addr_r,
                               stride: stride_n, conf: conf_n};
    end else begin
      row_upd.way[row_cur.victim] = '{valid: 1'b1, tag: s1_tag, last_addr: s1_addr_r,
                                      stride: '0, conf: '0};
      row_upd.victim = next_victim;
    end
  end

  assign pred_v = s1_v_r & hit & (conf_n == conf_max_lp) & (stride_n != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) fwd_v_r <= 1'b0;
    else         fwd_v_r <= s1_v_r & rd_v & (s1_idx == rd_idx);
  end

  always_ff @(posedge clk_i) begin
    fwd_row_r <= row_upd;
  end

  logic                    clearing, wr_v;
  logic [idx_width_lp-1:0] wr_addr;
  logic [row_width_lp-1:0] wr_data;

  assign clearing = (init_state_r == e_clear);
  assign wr_v     = clearing | s1_v_r;
  assign wr_addr  = clearing ? clear_idx_r : s1_idx;
  assign wr_data  = clearing ? '0 : row_upd;

  bsg_mem_1r1w_sync #(
    .width_p(row_width_lp),
    .els_p  (sets_p)
  ) rows (
    .clk_i   (clk_i),
    .w_v_i   (wr_v),
    .w_addr_i(wr_addr),
    .w_data_i(wr_data),
    .r_v_i   (rd_v),
    .r_addr_i(rd_idx),
    .r_data_o(rd_row_bits)
  );

  bp_be_rpt_nway_issue #(
    .vaddr_width_p (vaddr_width_p),
    .stride_width_p(stride_width_p),
    .degree_p      (degree_p)
  ) issue (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .pred_v_i     (pred_v),
    .pred_base_i  (s1_addr_r),
    .pred_stride_i(stride_n),
    .pred_pc_i    (s1_pc_r),
    .pf_v_o       (pf_v_o),
    .pf_ready_i   (pf_ready_i),
    .pf_addr_o    (pf_addr_o),
    .pf_pc_o      (pf_pc_o),
    .state_o      (issue_state_o)
  );

endmodule

// File: tb/tb_bp_be_rpt_nway.sv
module tb_bp_be_rpt_nway;
  import bp_be_pkg::*;

  localparam int vw   = bp_vaddr_width(e_bp_default_cfg);
  localparam int sets = 32;

  logic clk, reset_i, init_done_o, v_i, flush_i, pf_v_o, pf_ready_i;
  logic [vw-1:0] pc_i, eff_addr_i, pf_addr_o, pf_pc_o;
  bp_be_rpt_init_state_e  init_state;
  bp_be_rpt_issue_state_e issue_state;

  bp_be_rpt_nway #(
    .bp_params_p(e_bp_default_cfg), .sets_p(sets), .ways_p(4),
    .stride_width_p(12), .conf_width_p(2), .degree_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o),
    .v_i(v_i), .pc_i(pc_i), .eff_addr_i(eff_addr_i), .flush_i(flush_i),
    .pf_v_o(pf_v_o), .pf_ready_i(pf_ready_i), .pf_addr_o(pf_addr_o),
    .pf_pc_o(pf_pc_o), .init_state_o(init_state), .issue_state_o(issue_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [2*vw-1:0] exp_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_exp(input int unsigned pc, input int unsigned addr);
    exp_q.push_back({vw'(pc), vw'(addr)});
  endtask

  task automatic load(input int unsigned pc, input int unsigned addr);
    v_i = 1'b1;
    pc_i = vw'(pc);
    eff_addr_i = vw'(addr);
    @(posedge clk); #1;
    v_i = 1'b0;
  endtask

  task automatic train4(input int unsigned pc, input int unsigned base, input int unsigned stride);
    for (int i = 0; i < 4; i++) load(pc, base + i * stride);
  endtask

  task automatic wait_pf_v();
    int n = 0;
    while (!pf_v_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("pf_v_rise", 128'(pf_v_o), 128'(1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 128'(exp_q.size()), 128'(0));
    idle(4);
  endtask

  // Reset, check reset outputs, then time init_done while offering loads
  // that must be ignored during clearing.
  task automatic do_reset();
    int n = 0;
    bit done = 0;
    reset_i = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    @(posedge clk); #1;
    check("reset_init_done", 128'(init_done_o), 128'(0));
    check("reset_pf_v", 128'(pf_v_o), 128'(0));
    check("reset_pf_addr", 128'(pf_addr_o), 128'(0));
    check("reset_pf_pc", 128'(pf_pc_o), 128'(0));
    check("reset_init_state", 128'(init_state), 128'(e_reset));
    check("reset_issue_state", 128'(issue_state), 128'(e_idle));
    reset_i = 1'b0;
    while (!done && n < 100) begin
      n++;
      v_i = (n <= 5);
      pc_i = vw'(32'h11F);
      eff_addr_i = vw'(32'h3000 + n * 32'h10);
      @(posedge clk); #1;
      check("init_pf_v", 128'(pf_v_o), 128'(0));
      if (init_done_o) done = 1;
    end
    v_i = 1'b0;
    check("init_done_latency", 128'(n), 128'(sets + 1));
  endtask

  // scoreboard monitor: compare every presented request with the queue head
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_i && pf_v_o) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL pf_unexpected: got addr %0h pc %0h, required no request", pf_addr_o, pf_pc_o);
        end else begin
          check("pf_req", 128'({pf_pc_o, pf_addr_o}), 128'(exp_q[0]));
          if (pf_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i = 1'b1; v_i = 1'b0; pc_i = '0; eff_addr_i = '0;
    flush_i = 1'b0; pf_ready_i = 1'b1;

    // Reset and init latency, then reset again partway through clearing.
    do_reset();
    idle(5);
    reset_i = 1'b1;
    idle(1);
    reset_i = 1'b0;
    idle(10);
    do_reset();

    // Ascending stride 0x40, burst of two.
    train4(32'h100, 32'h1000, 32'h40);
    push_exp(32'h100, 32'h1140);
    push_exp(32'h100, 32'h1180);
    load(32'h100, 32'h1100);
    wait_drain();

    // Consumer stalls for five cycles; request must hold.
    do_reset();
    pf_ready_i = 1'b0;
    train4(32'h100, 32'h1000, 32'h40);
    push_exp(32'h100, 32'h1140);
    push_exp(32'h100, 32'h1180);
    load(32'h100, 32'h1100);
    wait_pf_v();
    repeat (5) begin
      check("stall_addr", 128'(pf_addr_o), 128'(32'h1140));
      check("stall_pc", 128'(pf_pc_o), 128'(32'h100));
      @(posedge clk); #1;
    end
    pf_ready_i = 1'b1;
    wait_drain();

    // Reset in the middle of a stalled burst.
    pf_ready_i = 1'b0;
    train4(32'h180, 32'h4000, 32'h20);
    push_exp(32'h180, 32'h40A0);
    push_exp(32'h180, 32'h40C0);
    load(32'h180, 32'h4080);
    wait_pf_v();
    do_reset();
    pf_ready_i = 1'b1;
    idle(4);

    // Five PCs sharing set 0: the fifth evicts the first, which must retrain.
    train4(32'h100, 32'h1000, 32'h40);
    push_exp(32'h100, 32'h1140);
    push_exp(32'h100, 32'h1180);
    load(32'h100, 32'h1100);
    wait_drain();
    load(32'h200, 32'h5000);
    load(32'h300, 32'h6000);
    load(32'h400, 32'h7000);
    load(32'h500, 32'h8000);
    idle(2);
    train4(32'h100, 32'h1140, 32'h40);
    idle(4);
    push_exp(32'h100, 32'h1280);
    push_exp(32'h100, 32'h12C0);
    load(32'h100, 32'h1240);
    wait_drain();

    // Descending stride.
    do_reset();
    train4(32'h140, 32'h2000, 32'hFFFF_FFF8);
`ifdef BP_BE_RPT_NEG_STRIDE_EN
    push_exp(32'h140, 32'h1FD8);
    push_exp(32'h140, 32'h1FD0);
`endif
    load(32'h140, 32'h1FE0);
    repeat (6) begin
`ifndef BP_BE_RPT_NEG_STRIDE_EN
      check("neg_no_pf", 128'(pf_v_o), 128'(0));
`endif
      @(posedge clk); #1;
    end
    wait_drain();

    // Flush the first unaccepted request, then retrigger from the same entry.
    do_reset();
    pf_ready_i = 1'b0;
    train4(32'h100, 32'h1000, 32'h40);
    push_exp(32'h100, 32'h1140);
    push_exp(32'h100, 32'h1180);
    load(32'h100, 32'h1100);
    wait_pf_v();
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    exp_q.delete();
    check("flush_pf_v", 128'(pf_v_o), 128'(0));
    pf_ready_i = 1'b1;
    idle(3);
    check("flush_quiet", 128'(pf_v_o), 128'(0));
    push_exp(32'h100, 32'h1180);
    push_exp(32'h100, 32'h11C0);
    load(32'h100, 32'h1140);
    wait_drain();

    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
